// File: rtl/full_adder_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_pkg
//
// Shared definitions for the full-adder built-in self-test engine:
//   state_t      - controller states (IDLE, APPLY, CHECK, FINISH)
//   NUM_VECTORS  - number of exhaustive {a,b,c} input combinations
//   golden_fa()  - reference full-adder model returning {carry, sum}
//
// The reference model is a plain function and is never built from the adder
// under test, so a design error in that adder cannot hide itself.
// -----------------------------------------------------------------------------
package full_adder_pkg;

    localparam int NUM_VECTORS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Reference full adder, result packed as {carry, sum}
    function automatic logic [1:0] golden_fa(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/full_adder_checker.sv
// -----------------------------------------------------------------------------
// full_adder_checker
//
// On-chip self-test engine for a combinational full adder. On a start request
// it walks all eight {a,b,c} combinations. Each combination is held for
// SETTLE_CYCLES cycles and the adder's response is then checked for one cycle
// against the reference model. The engine reports pass/fail, a mismatch count
// and a per-vector failure mask.
//
// Parameters:
//   SETTLE_CYCLES - cycles each vector is held before sampling (1..15)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   run request, only honoured while idle
//   a_o        out  operand a to the adder (vector MSB)
//   b_o        out  operand b to the adder
//   c_o        out  carry-in to the adder (vector LSB)
//   sum_i      in   adder sum
//   carry_i    in   adder carry-out
//   busy       out  high while vectors are being applied or checked
//   done       out  one-cycle pulse when a run completes
//   pass       out  last run had no mismatches
//   err_count  out  number of failing vectors in the last run (0..8)
//   fail_vec   out  bit i set when vector i failed
// -----------------------------------------------------------------------------
module full_adder_checker
    import full_adder_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    input  logic       sum_i,
    input  logic       carry_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_VEC    = 3'(NUM_VECTORS - 1);

    state_t     state;
    state_t     next_state;
    logic [2:0] vec;
    logic [3:0] settle_cnt;
    logic       settle_done;
    logic       last_vec;
    logic       mismatch;

    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign last_vec    = (vec == LAST_VEC);

    // A vector counts once even if both sum and carry are wrong
    assign mismatch = ({carry_i, sum_i} != golden_fa(vec[2], vec[1], vec[0]));

    // The vector register drives the adder directly, so the operands are
    // glitch-free and hold 3'b111 after a run until the next start or reset
    assign a_o = vec[2];
    assign b_o = vec[1];
    assign c_o = vec[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start)       next_state = APPLY;
            APPLY:   if (settle_done) next_state = CHECK;
            CHECK:   next_state = last_vec ? FINISH : APPLY;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            APPLY, CHECK: busy = 1'b1;
            FINISH:       done = 1'b1;
            default:      ;
        endcase
    end

    // Vector sequencing, settle timing and result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            vec        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_vec   <= '0;
            pass       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        vec        <= '0;
                        settle_cnt <= '0;
                        err_count  <= '0;
                        fail_vec   <= '0;
                        pass       <= 1'b0;
                    end
                end
                APPLY: begin
                    if (!settle_done) begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count     <= err_count + 4'd1;
                        fail_vec[vec] <= 1'b1;
                    end
                    // pass is resolved here, including this last vector's
                    // outcome, so it is already valid in the done cycle
                    if (last_vec) begin
                        pass <= (err_count == 4'd0) && !mismatch;
                    end else begin
                        vec        <= vec + 3'd1;
                        settle_cnt <= '0;
                    end
                end
                FINISH: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_full_adder_checker.sv
// -----------------------------------------------------------------------------
// tb_full_adder_checker
//
// Directed testbench for full_adder_checker. Two instances are used: one with
// the default settle time driving a full-adder model with selectable stuck-at
// faults, and one with SETTLE_CYCLES=3 driving a fault-free adder model.
// Cycle 0 is the cycle in which start is first seen high.
// -----------------------------------------------------------------------------
module tb_full_adder_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start1, start3;
    logic       a1, b1, c1, sum1, carry1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [7:0] fail1;
    logic       a3, b3, c3, sum3, carry3, busy3, done3, pass3;
    logic [3:0] err3;
    logic [7:0] fail3;

    // 0 = good adder, 1 = carry stuck-at-0, 2 = sum stuck-at-0
    int fault;

    int vectors_applied = 0;
    int miscompares     = 0;

    full_adder_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a_o(a1), .b_o(b1), .c_o(c1),
        .sum_i(sum1), .carry_i(carry1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fail1)
    );

    full_adder_checker #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .a_o(a3), .b_o(b3), .c_o(c3),
        .sum_i(sum3), .carry_i(carry3),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_vec(fail3)
    );

    // Adder attached to dut1, with optional stuck-at fault
    always_comb begin
        sum1   = a1 ^ b1 ^ c1;
        carry1 = (a1 & b1) | (a1 & c1) | (b1 & c1);
        if (fault == 1) carry1 = 1'b0;
        if (fault == 2) sum1   = 1'b0;
    end

    // Fault-free adder attached to dut3
    assign sum3   = a3 ^ b3 ^ c3;
    assign carry3 = (a3 & b3) | (a3 & c3) | (b3 & c3);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts a run on the selected instance and records what happens over the
    // following ncycles cycles; comparisons are made by the calling test
    task automatic observe_run(input bit use3, input int settle, input int ncycles,
                               input int repulse, input int hold_until,
                               output int first_done, output int second_done,
                               output int done_pulses, output int hold_bad,
                               output int busy_bad);
        logic [2:0] obs_vec;
        logic       obs_busy, obs_done;
        first_done  = -1;
        second_done = -1;
        done_pulses = 0;
        hold_bad    = 0;
        busy_bad    = 0;
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        tick();
        for (int c = 1; c <= ncycles; c++) begin
            if (use3) start3 = (c == repulse) || (c < hold_until);
            else      start1 = (c == repulse) || (c < hold_until);
            obs_vec  = use3 ? {a3, b3, c3} : {a1, b1, c1};
            obs_busy = use3 ? busy3 : busy1;
            obs_done = use3 ? done3 : done1;
            if (c <= 8 * (settle + 1)) begin
                if (obs_vec !== 3'((c - 1) / (settle + 1))) hold_bad++;
                if (obs_busy !== 1'b1) busy_bad++;
            end
            if (obs_done === 1'b1) begin
                done_pulses++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
                if (obs_busy !== 1'b0) busy_bad++;
            end
            tick();
        end
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; fault = 0;
        tick(); tick();
        vectors_applied++;
        if ({a1, b1, c1, busy1, done1, pass1, err1, fail1} !== 18'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_dut1: got %h, expected 0", {a1, b1, c1, busy1, done1, pass1, err1, fail1});
        end
        vectors_applied++;
        if ({a3, b3, c3, busy3, done3, pass3, err3, fail3} !== 18'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_dut3: got %h, expected 0", {a3, b3, c3, busy3, done3, pass3, err3, fail3});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_good_run;
        int fd, sd, np, hb, bb;
        fault = 0;
        observe_run(1'b0, 1, 20, -1, 0, fd, sd, np, hb, bb);
        vectors_applied++;
        if (fd !== 17) begin miscompares++; $display("[TB] FAIL good_done_cycle: got %0d, expected 17", fd); end
        vectors_applied++;
        if (np !== 1) begin miscompares++; $display("[TB] FAIL good_done_pulses: got %0d, expected 1", np); end
        vectors_applied++;
        if (hb !== 0) begin miscompares++; $display("[TB] FAIL good_vector_hold: %0d bad cycles, expected 0", hb); end
        vectors_applied++;
        if (bb !== 0) begin miscompares++; $display("[TB] FAIL good_busy: %0d bad cycles, expected 0", bb); end
        vectors_applied++;
        if ({pass1, err1, fail1} !== {1'b1, 4'd0, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL good_results: got pass=%0b err=%0d fail=%h, expected pass=1 err=0 fail=00", pass1, err1, fail1);
        end
        vectors_applied++;
        if ({a1, b1, c1} !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL good_idle_vector: got %b, expected 111", {a1, b1, c1});
        end
    endtask

    task automatic test_carry_fault;
        int fd, sd, np, hb, bb;
        fault = 1;
        observe_run(1'b0, 1, 20, -1, 0, fd, sd, np, hb, bb);
        vectors_applied++;
        if (fd !== 17) begin miscompares++; $display("[TB] FAIL carry_done_cycle: got %0d, expected 17", fd); end
        vectors_applied++;
        if ({pass1, err1, fail1} !== {1'b0, 4'd4, 8'hE8}) begin
            miscompares++;
            $display("[TB] FAIL carry_results: got pass=%0b err=%0d fail=%h, expected pass=0 err=4 fail=e8", pass1, err1, fail1);
        end
        fault = 0;
    endtask

    task automatic test_sum_fault_then_clear;
        int fd, sd, np, hb, bb;
        int done_at;
        fault = 2;
        observe_run(1'b0, 1, 20, -1, 0, fd, sd, np, hb, bb);
        vectors_applied++;
        if ({pass1, err1, fail1} !== {1'b0, 4'd4, 8'h96}) begin
            miscompares++;
            $display("[TB] FAIL sum_results: got pass=%0b err=%0d fail=%h, expected pass=0 err=4 fail=96", pass1, err1, fail1);
        end
        fault = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        vectors_applied++;
        if ({pass1, err1, fail1} !== {1'b0, 4'd0, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL clear_at_start: got pass=%0b err=%0d fail=%h, expected pass=0 err=0 fail=00", pass1, err1, fail1);
        end
        done_at = -1;
        for (int c = 1; c <= 30 && done_at < 0; c++) begin
            if (done1 === 1'b1) done_at = c;
            tick();
        end
        vectors_applied++;
        if (done_at !== 17) begin miscompares++; $display("[TB] FAIL clear_done_cycle: got %0d, expected 17", done_at); end
        vectors_applied++;
        if ({pass1, err1, fail1} !== {1'b1, 4'd0, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL clear_results: got pass=%0b err=%0d fail=%h, expected pass=1 err=0 fail=00", pass1, err1, fail1);
        end
    endtask

    task automatic test_settle3_repulse;
        int fd, sd, np, hb, bb;
        observe_run(1'b1, 3, 40, 5, 0, fd, sd, np, hb, bb);
        vectors_applied++;
        if (fd !== 33) begin miscompares++; $display("[TB] FAIL settle3_done_cycle: got %0d, expected 33", fd); end
        vectors_applied++;
        if (np !== 1) begin miscompares++; $display("[TB] FAIL settle3_done_pulses: got %0d, expected 1", np); end
        vectors_applied++;
        if (hb !== 0) begin miscompares++; $display("[TB] FAIL settle3_vector_hold: %0d bad cycles, expected 0", hb); end
        vectors_applied++;
        if ({pass3, err3, fail3} !== {1'b1, 4'd0, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL settle3_results: got pass=%0b err=%0d fail=%h, expected pass=1 err=0 fail=00", pass3, err3, fail3);
        end
    endtask

    task automatic test_reset_mid_run;
        int fd, sd, np, hb, bb;
        int stray_done;
        fault = 1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c < 9; c++) tick();
        // Vector 3 was checked in cycle 8 and fails with carry stuck-at-0
        vectors_applied++;
        if ({err1, fail1} !== {4'd1, 8'h08}) begin
            miscompares++;
            $display("[TB] FAIL midrun_partial: got err=%0d fail=%h, expected err=1 fail=08", err1, fail1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fault = 0;
        vectors_applied++;
        if ({a1, b1, c1, busy1, done1, pass1, err1, fail1} !== 18'h0) begin
            miscompares++;
            $display("[TB] FAIL midrun_reset_outputs: got %h, expected 0", {a1, b1, c1, busy1, done1, pass1, err1, fail1});
        end
        stray_done = 0;
        for (int c = 0; c < 25; c++) begin
            if (done1 === 1'b1 || busy1 === 1'b1) stray_done++;
            tick();
        end
        vectors_applied++;
        if (stray_done !== 0) begin miscompares++; $display("[TB] FAIL midrun_stays_idle: %0d active cycles, expected 0", stray_done); end
        observe_run(1'b0, 1, 20, -1, 0, fd, sd, np, hb, bb);
        vectors_applied++;
        if (fd !== 17) begin miscompares++; $display("[TB] FAIL after_reset_done_cycle: got %0d, expected 17", fd); end
        vectors_applied++;
        if ({pass1, err1, fail1} !== {1'b1, 4'd0, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL after_reset_results: got pass=%0b err=%0d fail=%h, expected pass=1 err=0 fail=00", pass1, err1, fail1);
        end
    endtask

    task automatic test_back_to_back;
        int fd, sd, np, hb, bb;
        fault = 0;
        observe_run(1'b0, 1, 45, -1, 40, fd, sd, np, hb, bb);
        vectors_applied++;
        if (fd !== 17) begin miscompares++; $display("[TB] FAIL b2b_first_done: got %0d, expected 17", fd); end
        vectors_applied++;
        if (sd !== 35) begin miscompares++; $display("[TB] FAIL b2b_second_done: got %0d, expected 35", sd); end
        vectors_applied++;
        if (np !== 2) begin miscompares++; $display("[TB] FAIL b2b_done_pulses: got %0d, expected 2", np); end
        vectors_applied++;
        if (bb !== 0) begin miscompares++; $display("[TB] FAIL b2b_busy: %0d bad cycles, expected 0", bb); end
        // A third run was re-triggered before start dropped; clear it
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst    = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        fault  = 0;
        test_reset();
        test_good_run();
        test_carry_fault();
        test_sum_fault_then_clear();
        test_settle3_repulse();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/full_adder_checker.md
# full_adder_checker

Synchronous self-test engine for the combinational `full_adder` block, responsible for both stimulus and response checking. It drives all eight `{a,b,c}` input combinations into an attached adder and samples the adder's `sum`/`carry` after a programmable settle time. Each sample is compared against a golden model, and the block reports pass/fail, a mismatch count and a per-vector failure mask. It sits beside the adder instance as an on-chip BIST.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles a vector is held before sampling. Legal range is 1..15.

Ports:
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: run request, sampled only in IDLE.
- `a_o`, output, 1: operand a to the adder.
- `b_o`, output, 1: operand b to the adder.
- `c_o`, output, 1: carry-in to the adder.
- `sum_i`, input, 1: adder sum output.
- `carry_i`, input, 1: adder carry output.
- `busy`, output, 1: high in APPLY and CHECK.
- `done`, output, 1: one-cycle pulse in FINISH.
- `pass`, output, 1: high when the last run had zero mismatches.
- `err_count`, output, 4: number of mismatching vectors in the last run, 0..8.
- `fail_vec`, output, 8: bit i is set when vector i mismatched.

## Operation
- The vector index `vec` is 3 bits wide, with `{a_o,b_o,c_o} = vec`. `a_o` is the MSB.
- Golden model:
  - `exp_sum = a^b^c`
  - `exp_carry = (a&b)|(a&c)|(b&c)`
- A mismatch is recorded when `sum_i != exp_sum` or `carry_i != exp_carry`. Each vector counts at most once, even if both outputs are wrong.
- FSM states are IDLE, APPLY, CHECK and FINISH.
  - IDLE -> APPLY when `start`=1. On entry: `vec`=0, settle counter=0, `err_count`=0, `fail_vec`=0, `pass`=0.
  - APPLY holds the vector for `SETTLE_CYCLES` cycles, then -> CHECK.
  - CHECK is one cycle. It compares `sum_i`/`carry_i` present during the cycle and updates `err_count`/`fail_vec` at the closing edge.
    - If `vec`==7 -> FINISH.
    - Otherwise `vec`+1 -> APPLY, with the settle counter cleared.
  - FINISH is one cycle. `done`=1, `pass = (err_count==0)`, then -> IDLE.
- Outputs `{a_o,b_o,c_o}` are registered and remain stable through APPLY and CHECK of each vector. They hold their last value (3'b111) in FINISH and IDLE until the next run or reset.
- `pass`, `err_count` and `fail_vec` hold until the next accepted `start` or `rst`.
- `start` is ignored in APPLY, CHECK and FINISH; it is not queued.
- A `start` held high continuously re-triggers in the IDLE cycle following FINISH.

## Timing
- Reset values: all outputs are 0; state is IDLE; `vec`=0.
- `rst` has priority over everything. Asserting it mid-run aborts immediately, clears all results, and no `done` is produced.
- Each vector occupies `SETTLE_CYCLES`+1 cycles.
- The `start` edge is cycle 0. APPLY of vector 0 begins in cycle 1.
- `done` is high in cycle `8*(SETTLE_CYCLES+1)+1`. With the default `SETTLE_CYCLES`=1, that is cycle 17.
- `busy` rises in cycle 1 and falls at FINISH, so it is low in the same cycle `done` is high.
- `err_count` saturates naturally at 8; no wrap is possible, since 4 bits cover 0..8.
- The adder is combinational. Any extra DUT path delay must be absorbed by `SETTLE_CYCLES`.

## Structure
Shared package `full_adder_pkg` contains:
- A `state_t` enum with IDLE, APPLY, CHECK and FINISH.
- `NUM_VECTORS = 8`.
- A `golden_fa(a,b,c)` function returning `{carry,sum}`.

No sub-module is used. The golden model is the package function, deliberately not a second `full_adder` instance, so that a common-mode design bug cannot mask itself.

## Test plan
- Good `full_adder` attached, `start` pulsed -> `done` in cycle 17, `pass`=1, `err_count`=0, `fail_vec`=8'h00; vectors 0..7 each held 2 cycles.
- Faulty model with carry stuck-at-0 -> `pass`=0, `err_count`=4, `fail_vec`=8'hE8.
- Faulty model with sum stuck-at-0 -> `err_count`=4, `fail_vec`=8'h96; then start a run with a good adder -> results cleared at start, final `pass`=1, `fail_vec`=8'h00.
- `SETTLE_CYCLES`=3, `start` re-pulsed in cycle 5 -> ignored; `done` only in cycle 33.
- `rst` asserted in cycle 9 of a run -> next cycle all outputs 0, IDLE, no `done`; a subsequent `start` runs cleanly.
- `start` held high for 40 cycles -> back-to-back runs, with `done` in cycles 17 and 35 and no extra pulses.
